mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle main control state machine for the MIPS-subset datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every datapath select and enable. This includes pc_source, which feeds the PC select mux, and pc_en, the PC register load enable.
- Sits between the instruction register opcode field and the datapath. Moore-style: outputs decode from the state register, except pc_en.

Parameters:
- None. Opcode values are fixed: R=6'b000000, LW=6'b100011, SW=6'b101011, BEQ=6'b000100, J=6'b000010, ADDI=6'b001000.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE onward
zero  in  1  ALU zero flag
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
pc_en  out  1  combinational: pc_write | (pc_write_cond & zero)
pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump address
i_or_d  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
mem_to_reg  out  1  register write data: 0 ALUOut, 1 MDR
reg_dst  out  1  destination register: 0 rt, 1 rd
reg_write  out  1  register file write
alu_src_a  out  1  ALU A input: 0 PC, 1 register A
alu_src_b  out  2  ALU B input: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2
alu_op  out  2  00 add, 01 subtract, 10 use funct field
illegal_op  out  1  one-cycle pulse on unrecognised opcode
state  out  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, RESET=12.
- Reset: rst_n low asynchronously forces state=RESET and illegal_op=0.
- In RESET all outputs are 0, including pc_en.
- On the first clk edge after rst_n rises, RESET -> FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> by opcode: LW/SW -> MEM_ADDR, R -> EXECUTE, BEQ -> BRANCH, J -> JUMP, ADDI -> ADDI_EXEC, anything else -> FETCH.
  - MEM_ADDR -> MEM_READ (LW) or MEM_WRITE (SW); opcode is re-sampled here.
  - MEM_READ -> MEM_WB.
  - EXECUTE -> R_WB.
  - ADDI_EXEC -> ADDI_WB.
  - MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB -> FETCH.
- Outputs per state; any output not listed is 0:
  - FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=00, pc_write=1, pc_source=00.
  - DECODE: alu_src_b=11, alu_op=00 (computes branch target).
  - MEM_ADDR: alu_src_a=1, alu_src_b=10.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_write=1, reg_dst=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10.
  - ADDI_WB: reg_write=1, reg_dst=0.
- Latency in cycles: R=4, LW=5, SW=4, BEQ=3, J=3, ADDI=4, illegal=2.
- illegal_op: registered. High for exactly the one cycle following a DECODE with an unrecognised opcode, which is the next FETCH cycle.
- pc_en: asserted at most once per instruction, except that FETCH plus BRANCH-taken or FETCH plus JUMP give two loads, which is intended.
- Reset mid-instruction: abandons the instruction immediately, with no write strobes after rst_n falls.

Optional Feature:
- Macro: MC_MEM_READY_EN.
- When defined:
  - Adds input port mem_ready (1 bit).
  - FETCH, MEM_READ and MEM_WRITE hold their state while mem_ready=0 and advance when mem_ready=1.
  - mem_read and mem_write stay asserted for the whole hold.
  - In FETCH, pc_write and ir_write equal mem_ready, so the PC increments exactly once per fetch.
- When undefined: the port is absent and every state lasts one cycle, as in Behaviour.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 during reset; state 12 -> 0 on the first edge; pc_en=1 and pc_source=00 in FETCH.
- opcode=6'b100011 (LW) -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; pc_en high only in FETCH.
- opcode=6'b000100 (BEQ) -> with zero=1: pc_en=1 and pc_source=01 in state 8; with zero=0: pc_en=0 in state 8; next state 0 in both cases.
- opcode=6'b000010 (J) -> states 0,1,9,0; pc_write=1 and pc_source=10 in state 9. Then opcode=6'b111111 -> states 0,1,0 with illegal_op=1 for exactly one cycle.
- rst_n dropped asynchronously mid-cycle while in MEM_WRITE -> state=12 and mem_write=0 before the next clk edge.
- MC_MEM_READY_EN defined, mem_ready=0 for 3 cycles in FETCH then 1 -> state stays 0 for 4 cycles; pc_en=1 only in the 4th cycle; ir_write pulses once.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle main FSM and the MIPS-subset datapath.
// master = control FSM side, slave = datapath side.
interface mc_control_fsm_if;
   logic [5:0] opcode;
   logic       zero;
   logic       pc_write;
   logic       pc_write_cond;
   logic       pc_en;
   logic [1:0] pc_source;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      input  opcode, zero,
      output pc_write, pc_write_cond, pc_en, pc_source, i_or_d, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             illegal_op, state
   );

   modport slave (
      output opcode, zero,
      input  pc_write, pc_write_cond, pc_en, pc_source, i_or_d, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             illegal_op, state
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset main control FSM; Moore outputs except pc_en (combinational with zero).
// Latency R=4, LW=5, SW=4, BEQ=3, J=3, ADDI=4, illegal=2 cycles; no backpressure by default.
// MC_MEM_READY_EN adds mem_ready: FETCH/MEM_READ/MEM_WRITE hold with strobes asserted until it is high.
module mc_control_fsm (
   input  logic                clk,
   input  logic                rst_n,
`ifdef MC_MEM_READY_EN
   input  logic                mem_ready,
`endif
   mc_control_fsm_if.master    bus
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXECUTE   = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11,
      RESET     = 4'd12
   } state_t;

   state_t     state_q, state_d;
   logic       illegal_q, illegal_d;
   logic       ready;

   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] pc_source, alu_src_b, alu_op;

`ifdef MC_MEM_READY_EN
   assign ready = mem_ready;
`else
   assign ready = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RESET;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      illegal_d     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;

      case (state_q)
         RESET: state_d = FETCH;
         FETCH: begin
            // PC and IR load only on the accepted cycle so the PC advances once per fetch
            mem_read  = 1'b1;
            ir_write  = ready;
            pc_write  = ready;
            alu_src_b = 2'b01;
            if (ready) state_d = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_R:         state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               OP_ADDI:      state_d = ADDI_EXEC;
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            // an opcode that changed to neither LW nor SW issues no memory strobe
            if (bus.opcode == OP_LW)      state_d = MEM_READ;
            else if (bus.opcode == OP_SW) state_d = MEM_WRITE;
            else                          state_d = FETCH;
         end
         MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (ready) state_d = MEM_WB;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = FETCH;
         end
         MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (ready) state_d = FETCH;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = R_WB;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            state_d       = FETCH;
         end
         JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = FETCH;
         end
         ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = ADDI_WB;
         end
         ADDI_WB: begin
            reg_write = 1'b1;
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   assign bus.pc_write      = pc_write;
   assign bus.pc_write_cond = pc_write_cond;
   assign bus.pc_en         = pc_write | (pc_write_cond & bus.zero);
   assign bus.pc_source     = pc_source;
   assign bus.i_or_d        = i_or_d;
   assign bus.mem_read      = mem_read;
   assign bus.mem_write     = mem_write;
   assign bus.ir_write      = ir_write;
   assign bus.mem_to_reg    = mem_to_reg;
   assign bus.reg_dst       = reg_dst;
   assign bus.reg_write     = reg_write;
   assign bus.alu_src_a     = alu_src_a;
   assign bus.alu_src_b     = alu_src_b;
   assign bus.alu_op        = alu_op;
   assign bus.illegal_op    = illegal_q;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: state sequences and per-state control outputs.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mc_control_fsm;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mc_control_fsm_if bus();

`ifdef MC_MEM_READY_EN
   logic mem_ready = 1'b1;
   mc_control_fsm dut (.clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .bus(bus));
`else
   mc_control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   // {pc_write,pc_write_cond,pc_source, i_or_d,mem_read,mem_write,ir_write,
   //  mem_to_reg,reg_dst,reg_write,alu_src_a, alu_src_b,alu_op}
   function automatic logic [15:0] ctl_vec();
      return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
              bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
              bus.alu_src_a, bus.alu_src_b, bus.alu_op};
   endfunction

   task automatic test_reset();
      bus.opcode = 6'b000000;
      bus.zero   = 1'b0;
      rst_n      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.state !== 4'd12 || ctl_vec() !== 16'h0 || bus.pc_en !== 1'b0 || bus.illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs cyc %0d: state %0d ctl %h pc_en %b ill %b, want state 12 all zero",
                     i, bus.state, ctl_vec(), bus.pc_en, bus.illegal_op);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd0 || bus.pc_en !== 1'b1 || bus.pc_source !== 2'b00) begin
         errors++;
         $display("FAIL reset_to_fetch: state %0d pc_en %b pc_source %b, want 0 1 00",
                  bus.state, bus.pc_en, bus.pc_source);
      end
   endtask

   task automatic test_outputs();
      logic [15:0] tbl [13];
      logic [5:0]  ops [6];
      logic [3:0]  seq [6][5];
      int          len [6];
      tbl[0]  = 16'b1000_0101_0000_0100;
      tbl[1]  = 16'b0000_0000_0000_1100;
      tbl[2]  = 16'b0000_0000_0001_1000;
      tbl[3]  = 16'b0000_1100_0000_0000;
      tbl[4]  = 16'b0000_0000_1010_0000;
      tbl[5]  = 16'b0000_1010_0000_0000;
      tbl[6]  = 16'b0000_0000_0001_0010;
      tbl[7]  = 16'b0000_0000_0110_0000;
      tbl[8]  = 16'b0101_0000_0001_0001;
      tbl[9]  = 16'b1010_0000_0000_0000;
      tbl[10] = 16'b0000_0000_0001_1000;
      tbl[11] = 16'b0000_0000_0010_0000;
      tbl[12] = 16'b0;
      ops[0] = 6'b000000; seq[0] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};  len[0] = 4;
      ops[1] = 6'b101011; seq[1] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};  len[1] = 4;
      ops[2] = 6'b001000; seq[2] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0}; len[2] = 4;
      ops[3] = 6'b100011; seq[3] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};  len[3] = 5;
      ops[4] = 6'b000010; seq[4] = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0};  len[4] = 3;
      ops[5] = 6'b000100; seq[5] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0};  len[5] = 3;
      bus.zero = 1'b0;
      for (int n = 0; n < 6; n++) begin
         bus.opcode = ops[n];
         for (int k = 0; k < len[n]; k++) begin
            checks++;
            if (bus.state !== seq[n][k] || ctl_vec() !== tbl[seq[n][k]]) begin
               errors++;
               $display("FAIL outputs op %b step %0d: state %0d ctl %b, want state %0d ctl %b",
                        ops[n], k, bus.state, ctl_vec(), seq[n][k], tbl[seq[n][k]]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_lw();
      logic [3:0] seq [6];
      seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      bus.opcode = 6'b100011;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (bus.state !== seq[k] || bus.reg_write !== (seq[k] == 4'd4) ||
             bus.mem_to_reg !== (seq[k] == 4'd4) || bus.pc_en !== (seq[k] == 4'd0)) begin
            errors++;
            $display("FAIL lw step %0d: state %0d rw %b m2r %b pc_en %b, want state %0d",
                     k, bus.state, bus.reg_write, bus.mem_to_reg, bus.pc_en, seq[k]);
         end
         if (k < 5) @(negedge clk);
      end
   endtask

   task automatic test_beq();
      bus.opcode = 6'b000100;
      for (int z = 1; z >= 0; z--) begin
         bus.zero = 1'b1;
         @(negedge clk);
         @(negedge clk);
         bus.zero = z[0];
         #1;
         checks++;
         if (bus.state !== 4'd8 || bus.pc_en !== z[0] || bus.pc_source !== 2'b01) begin
            errors++;
            $display("FAIL beq zero=%0d: state %0d pc_en %b pc_source %b, want 8 %0d 01",
                     z, bus.state, bus.pc_en, bus.pc_source, z);
         end
         @(negedge clk);
         checks++;
         if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL beq_next zero=%0d: state %0d want 0", z, bus.state);
         end
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_jump_illegal();
      bus.opcode = 6'b000010;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd9 || bus.pc_write !== 1'b1 || bus.pc_source !== 2'b10 || bus.pc_en !== 1'b1) begin
         errors++;
         $display("FAIL jump: state %0d pc_write %b pc_source %b pc_en %b, want 9 1 10 1",
                  bus.state, bus.pc_write, bus.pc_source, bus.pc_en);
      end
      @(negedge clk);
      bus.opcode = 6'b111111;
      checks++;
      if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0) begin
         errors++;
         $display("FAIL illegal_pre: state %0d ill %b, want 0 0", bus.state, bus.illegal_op);
      end
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd1 || bus.illegal_op !== 1'b0) begin
         errors++;
         $display("FAIL illegal_decode: state %0d ill %b, want 1 0", bus.state, bus.illegal_op);
      end
      @(negedge clk);
      bus.opcode = 6'b000010;
      checks++;
      if (bus.state !== 4'd0 || bus.illegal_op !== 1'b1) begin
         errors++;
         $display("FAIL illegal_pulse: state %0d ill %b, want 0 1", bus.state, bus.illegal_op);
      end
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd1 || bus.illegal_op !== 1'b0) begin
         errors++;
         $display("FAIL illegal_clear: state %0d ill %b, want 1 0", bus.state, bus.illegal_op);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      bus.opcode = 6'b101011;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.state !== 4'd5 || bus.mem_write !== 1'b1) begin
         errors++;
         $display("FAIL sw_mem_write: state %0d mem_write %b, want 5 1", bus.state, bus.mem_write);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.state !== 4'd12 || bus.mem_write !== 1'b0 || ctl_vec() !== 16'h0 || bus.pc_en !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: state %0d mem_write %b ctl %h pc_en %b, want 12 0 0 0",
                  bus.state, bus.mem_write, ctl_vec(), bus.pc_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.state !== 4'd0) begin
         errors++;
         $display("FAIL async_reset_recover: state %0d want 0", bus.state);
      end
   endtask

`ifdef MC_MEM_READY_EN
   task automatic test_mem_ready();
      int irw = 0;
      bus.opcode = 6'b000010;
      mem_ready  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) mem_ready = 1'b1;
         #1;
         irw += int'(bus.ir_write);
         checks++;
         if (bus.state !== 4'd0 || bus.pc_en !== (k == 3) || bus.mem_read !== 1'b1) begin
            errors++;
            $display("FAIL mem_ready_hold cyc %0d: state %0d pc_en %b mem_read %b", k,
                     bus.state, bus.pc_en, bus.mem_read);
         end
         @(negedge clk);
      end
      checks++;
      if (bus.state !== 4'd1 || irw != 1) begin
         errors++;
         $display("FAIL mem_ready_advance: state %0d ir_write pulses %0d, want 1 1", bus.state, irw);
      end
      @(negedge clk);
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_outputs();
      test_lw();
      test_beq();
      test_jump_illegal();
      test_async_reset();
`ifdef MC_MEM_READY_EN
      test_mem_ready();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end
endmodule
